// File: rtl/mux_pkg.sv
// Shared types for the registered scanning channel selector.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MANUAL,
        SCAN
    } state_t;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

endpackage

// File: rtl/dwell_counter.sv
// Counts enabled cycles spent on one scan channel; tc marks the last cycle of a dwell.
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(DWELL - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            if (tc) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mux_scan_sel.sv
// Registered M-channel selector: manual channel pick or round-robin scan with per-channel dwell.
module mux_scan_sel
    import mux_pkg::*;
#(
    parameter  int N     = 2,
    parameter  int M     = 4,
    parameter  int DWELL = 4,
    localparam int SW    = $clog2(M)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic [SW-1:0]       sel,
    input  logic [M-1:0][N-1:0] data_in,
    output logic [N-1:0]        F,
    output logic [SW-1:0]       ch,
    output logic                valid,
    output logic                wrap
);

    state_t        state, state_nxt;
    logic [SW-1:0] ch_nxt;
    logic          wrap_nxt;
    logic          dwell_clr, dwell_inc, dwell_tc;

    // Out-of-range selects (only possible when M is not a power of two) pin to the last channel.
    function automatic logic [SW-1:0] clamp_sel(input logic [SW-1:0] s);
        if (int'(s) > M - 1) begin
            return SW'(M - 1);
        end
        return s;
    endfunction

    dwell_counter #(
        .DWELL(DWELL)
    ) u_dwell (
        .clk(clk),
        .rst(rst),
        .clr(dwell_clr),
        .inc(dwell_inc),
        .tc (dwell_tc)
    );

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        wrap_nxt  = 1'b0;
        dwell_clr = 1'b0;
        dwell_inc = 1'b0;
        if (en) begin
            if (mode_e'(mode) == MODE_MANUAL) begin
                state_nxt = MANUAL;
                ch_nxt    = clamp_sel(sel);
                dwell_clr = 1'b1;
            end else if (state != SCAN) begin
                // Entering scan always restarts at channel 0 and never counts as a wrap.
                state_nxt = SCAN;
                ch_nxt    = '0;
                dwell_clr = 1'b1;
            end else begin
                dwell_inc = 1'b1;
                if (dwell_tc) begin
                    if (ch == SW'(M - 1)) begin
                        ch_nxt   = '0;
                        wrap_nxt = 1'b1;
                    end else begin
                        ch_nxt = ch + SW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ch    <= '0;
            F     <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            wrap  <= wrap_nxt;
            // F re-samples every enabled cycle so live changes on the selected channel show through.
            if (en) begin
                ch    <= ch_nxt;
                F     <= data_in[ch_nxt];
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Bench for mux_scan_sel: directed vector table, randomized run against a scan-position model, M=3 corner cases.
module tb_mux_scan_sel;

    logic       clk = 1'b0;
    logic       rst, en, mode;
    logic [1:0] sel;
    logic [7:0] din;
    logic [1:0] f4, ch4, f3, ch3;
    logic       v4, w4, v3, w3;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mux_scan_sel #(.N(2), .M(4), .DWELL(2)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .data_in(din),
        .F(f4), .ch(ch4), .valid(v4), .wrap(w4)
    );

    mux_scan_sel #(.N(2), .M(3), .DWELL(1)) dut3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .data_in(din[5:0]),
        .F(f3), .ch(ch3), .valid(v3), .wrap(w3)
    );

    typedef struct {
        logic       rst, en, mode;
        logic [1:0] sel;
        logic [7:0] din;
        logic [1:0] f, ch;
        logic       v, w;
    } vec_t;

    vec_t tbl[29];

    function automatic vec_t mk(logic r, logic e, logic md, logic [1:0] s, logic [7:0] d,
                                logic [1:0] f, logic [1:0] c, logic v, logic w);
        vec_t t;
        t.rst = r; t.en = e; t.mode = md; t.sel = s; t.din = d;
        t.f = f; t.ch = c; t.v = v; t.w = w;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: scan position is a plain count of enabled scan cycles since entry.
    int m_t[2], m_ch[2], m_f[2];
    bit m_scan[2], m_v[2], m_w[2];

    task automatic model_step(input int id, input int m, input int d, input logic r,
                              input logic e, input logic md, input int s, input logic [7:0] di);
        if (r) begin
            m_t[id] = 0; m_ch[id] = 0; m_f[id] = 0;
            m_scan[id] = 0; m_v[id] = 0; m_w[id] = 0;
        end else if (e) begin
            m_w[id] = 0;
            if (!md) begin
                m_scan[id] = 0;
                m_ch[id] = (s > m - 1) ? m - 1 : s;
            end else begin
                if (!m_scan[id]) begin
                    m_scan[id] = 1;
                    m_t[id] = 0;
                end else begin
                    m_t[id]++;
                end
                m_ch[id] = (m_t[id] / d) % m;
                m_w[id] = (m_t[id] != 0) && (m_t[id] % (m * d) == 0);
            end
            m_f[id] = int'((di >> (2 * m_ch[id])) & 8'h3);
            m_v[id] = 1;
        end else begin
            m_w[id] = 0;
        end
    endtask

    initial begin
        tbl[0]  = mk(1, 1, 1, 0, 8'he4, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 1, 0, 8'he4, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 2, 8'he4, 2, 2, 1, 0);
        tbl[3]  = mk(0, 1, 0, 2, 8'hd4, 1, 2, 1, 0);
        tbl[4]  = mk(0, 1, 1, 0, 8'he4, 0, 0, 1, 0);
        tbl[5]  = mk(0, 1, 1, 0, 8'he4, 0, 0, 1, 0);
        tbl[6]  = mk(0, 1, 1, 0, 8'he4, 1, 1, 1, 0);
        tbl[7]  = mk(0, 1, 1, 0, 8'he4, 1, 1, 1, 0);
        tbl[8]  = mk(0, 1, 1, 0, 8'he4, 2, 2, 1, 0);
        tbl[9]  = mk(0, 1, 1, 0, 8'he4, 2, 2, 1, 0);
        tbl[10] = mk(0, 1, 1, 0, 8'he4, 3, 3, 1, 0);
        tbl[11] = mk(0, 1, 1, 0, 8'he4, 3, 3, 1, 0);
        tbl[12] = mk(0, 1, 1, 0, 8'he4, 0, 0, 1, 1);
        tbl[13] = mk(0, 1, 1, 0, 8'he4, 0, 0, 1, 0);
        tbl[14] = mk(0, 1, 1, 0, 8'he4, 1, 1, 1, 0);
        tbl[15] = mk(0, 0, 1, 0, 8'he4, 1, 1, 1, 0);
        tbl[16] = mk(0, 0, 1, 3, 8'h00, 1, 1, 1, 0);
        tbl[17] = mk(0, 0, 0, 3, 8'he4, 1, 1, 1, 0);
        tbl[18] = mk(0, 1, 1, 0, 8'he4, 1, 1, 1, 0);
        tbl[19] = mk(0, 1, 1, 0, 8'he4, 2, 2, 1, 0);
        tbl[20] = mk(0, 1, 1, 0, 8'he4, 2, 2, 1, 0);
        tbl[21] = mk(0, 1, 1, 0, 8'he4, 3, 3, 1, 0);
        tbl[22] = mk(0, 1, 0, 1, 8'he4, 1, 1, 1, 0);
        tbl[23] = mk(0, 1, 1, 1, 8'he4, 0, 0, 1, 0);
        tbl[24] = mk(0, 1, 1, 1, 8'he4, 0, 0, 1, 0);
        tbl[25] = mk(0, 1, 1, 1, 8'he4, 1, 1, 1, 0);
        tbl[26] = mk(1, 1, 1, 1, 8'he4, 0, 0, 0, 0);
        tbl[27] = mk(0, 0, 1, 1, 8'he4, 0, 0, 0, 0);
        tbl[28] = mk(0, 1, 1, 1, 8'he4, 0, 0, 1, 0);

        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; din = 8'he4;
        @(negedge clk);

        for (int i = 0; i < 29; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; mode = tbl[i].mode;
            sel = tbl[i].sel; din = tbl[i].din;
            tick();
            check($sformatf("vec%0d.F", i), int'(f4), int'(tbl[i].f));
            check($sformatf("vec%0d.ch", i), int'(ch4), int'(tbl[i].ch));
            check($sformatf("vec%0d.valid", i), int'(v4), int'(tbl[i].v));
            check($sformatf("vec%0d.wrap", i), int'(w4), int'(tbl[i].w));
        end

        for (int i = 0; i < 400; i++) begin
            rst  = (i == 0) || ($urandom_range(0, 39) == 0);
            en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 11) == 0) mode = ~mode;
            sel  = 2'($urandom_range(0, 3));
            din  = 8'($urandom);
            model_step(0, 4, 2, rst, en, mode, int'(sel), din);
            model_step(1, 3, 1, rst, en, mode, int'(sel), din);
            tick();
            check("rnd4.F", int'(f4), m_f[0]);
            check("rnd4.ch", int'(ch4), m_ch[0]);
            check("rnd4.valid", int'(v4), int'(m_v[0]));
            check("rnd4.wrap", int'(w4), int'(m_w[0]));
            check("rnd3.F", int'(f3), m_f[1]);
            check("rnd3.ch", int'(ch3), m_ch[1]);
            check("rnd3.valid", int'(v3), int'(m_v[1]));
            check("rnd3.wrap", int'(w3), int'(m_w[1]));
        end

        // M=3: select 3 clamps to channel 2; scan wraps 2 -> 0 with a pulse.
        rst = 1'b1; en = 1'b1; mode = 1'b0; sel = 2'd3; din = 8'he4;
        tick();
        rst = 1'b0;
        tick();
        check("m3.clamp.ch", int'(ch3), 2);
        check("m3.clamp.F", int'(f3), 2);
        mode = 1'b1;
        tick();
        check("m3.entry.ch", int'(ch3), 0);
        check("m3.entry.wrap", int'(w3), 0);
        tick();
        check("m3.s1.ch", int'(ch3), 1);
        tick();
        check("m3.s2.ch", int'(ch3), 2);
        check("m3.s2.wrap", int'(w3), 0);
        tick();
        check("m3.wrap.ch", int'(ch3), 0);
        check("m3.wrap.F", int'(f3), 0);
        check("m3.wrap.wrap", int'(w3), 1);
        tick();
        check("m3.after.ch", int'(ch3), 1);
        check("m3.after.wrap", int'(w3), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_sel.md
# mux_scan_sel

Registered, parametrised M-channel, N-bit selector. It is the sequential successor of the team's 4:1 opcode-selected mux. It has two modes:
- **Manual:** the channel is chosen by `sel`.
- **Scan:** the block steps through channels round-robin, holding each one for DWELL cycles.

It sits between parallel data sources (switch banks, counters) and a single display/consumer path. It reports the active channel and a wrap pulse for downstream framing.

## Interface
- `N`, 2, data width per channel (≥1)
- `M`, 4, channel count (≥2; need not be a power of two)
- `DWELL`, 4, cycles each channel is held in scan mode (≥1)
- `SW` (localparam), $clog2(M), channel index width
- `clk`  in  1  clock; all state changes on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  advance enable; 0 freezes all state and outputs
- `mode`  in  1  0 = manual, 1 = scan
- `sel`  in  SW  channel select, used in manual mode only
- `data_in`  in  [M-1:0][N-1:0]  channel data, packed
- `F`  out  N  registered selected data
- `ch`  out  SW  channel currently driving `F`
- `valid`  out  1  `F` holds data sampled since reset
- `wrap`  out  1  one-cycle pulse when scan advances from M-1 to 0

## Operation
- FSM states: IDLE, MANUAL, SCAN. `rst` forces IDLE.
- Reset values: F=0, ch=0, valid=0, wrap=0, dwell counter=0.
- `en`=0: state, ch, F, valid and dwell counter all hold; wrap=0.
- `en`=1, `mode`=0 (any state):
  - next ch = sel, clamped to M-1 if sel ≥ M.
  - dwell counter ← 0; state ← MANUAL.
- `en`=1, `mode`=1, state ≠ SCAN (entering scan):
  - next ch = 0, dwell ← 0, state ← SCAN.
  - wrap=0; entry is not a wrap.
- `en`=1, `mode`=1, state = SCAN:
  - If dwell = DWELL-1: dwell ← 0 and ch advances (ch+1, or 0 after M-1).
  - When that advance goes from M-1 to 0, wrap=1 for that cycle.
  - Otherwise dwell increments and ch holds.
- DWELL=1: ch advances every enabled cycle.
- Every enabled cycle: F ← data_in[next ch], ch ← next ch, valid ← 1.
  - F therefore tracks live changes of the selected channel, not just changes at channel switches.
- Mode change mid-dwell:
  - manual→scan always restarts at channel 0.
  - scan→manual takes effect on the same edge and the dwell count is discarded.
- `rst` mid-scan has priority over `en` and `mode`. All outputs return to reset values on that edge.

## Timing
- Latency from `data_in`/`sel` to `F`/`ch` is one cycle. No combinational input→output path.
- ch, F and wrap are mutually consistent in the same cycle. wrap is high exactly when ch becomes 0 via advance.
- In scan with `en` held high, channel k is presented for exactly DWELL consecutive cycles. A full rotation takes M·DWELL cycles.
- valid rises on the first enabled edge after reset and stays high until the next `rst`.

## Structure
- Shared package `mux_pkg`:
  - `state_t` enum (IDLE, MANUAL, SCAN).
  - `mode_e` (MODE_MANUAL=0, MODE_SCAN=1).
- Sub-module `dwell_counter`:
  - Parameter DWELL; inputs clk, rst, clr, inc; output `tc` = count at DWELL-1.
  - It holds the dwell count; the top FSM owns ch, F, valid and wrap.
- Counter width is $clog2(DWELL), minimum 1 bit.

## Test plan
N=2, M=4, DWELL=2; data_in = {3:2'b11, 2:2'b10, 1:2'b01, 0:2'b00} unless noted.
- **Reset:** rst=1 for 2 cycles with en=1, mode=1 → F=0, ch=0, valid=0, wrap=0 throughout.
- **Manual select:** mode=0, en=1, sel=2 → after one edge F=2'b10, ch=2, valid=1. Change data_in[2] to 2'b01 → F=2'b01 next cycle.
- **Scan rotation:** mode=1, en=1 from IDLE → ch sequence 0,0,1,1,2,2,3,3,0,… and F sequence 00,00,01,01,10,10,11,11,00. wrap=1 only in the cycle ch returns to 0.
- **Freeze:** en=0 for 3 cycles mid-scan at ch=1 (dwell=0) → ch=1 and F=01 hold, wrap=0. On re-enable, ch=1 for one more cycle, then ch=2.
- **Mode switching:** scan at ch=3, switch to mode=0 with sel=1 → next edge ch=1, F=01. Switch back to mode=1 → next edge ch=0, wrap=0.
- **Non-power-of-two channel count:** M=3, sel=3 in manual → ch=2 (clamped). In scan, ch wraps 2→0 with a wrap pulse.
